avg3x3_window_filter: RTL and testbench
=======================================

// Module: avg3x3_window_filter
// PURPOSE
// - 3x3 box (mean) filter for streaming grayscale video; sits right after the line-alignment block.
// - Each valid beat brings one vertical column of LINE_NUM aligned pixels.
// - Sums a 3x3 window, registers the sum, then divides it by 9 to produce an averaged pixel.
// - Both the raw window sum and the averaged pixel are output.
// PARAMETERS
// - PIXEL_WIDTH  8    bits per pixel
// - LINE_NUM     3    pixels per input column (vertical kernel size; fixed at 3)
// - KX_WIDTH     3    horizontal kernel size (fixed at 3)
// - IMAGE_WIDTH  128  pixels per line; column counter modulus
// PORTS
// - clk        in   1                      single clock, rising edge
// - arstn      in   1                      reset, asynchronous, active-high (1 = reset)
// - data_in    in   PIXEL_WIDTH*LINE_NUM   column; [PW-1:0]=row0, [2PW-1:PW]=row1, [3PW-1:2PW]=row2
// - din_valid  in   1                      data_in valid this cycle
// - sum_out    out  PIXEL_WIDTH+4          3x3 window sum (max 2295 fits in 12 b)
// - sum_valid  out  1                      sum_out valid
// - data_out   out  PIXEL_WIDTH            averaged pixel
// - dout_valid out  1                      data_out valid
// BEHAVIOUR
// - Reset (async assert, sync release) clears all registers to 0:
//   - sum_out, sum_valid, data_out and dout_valid are 0.
//   - Column counter is 0.
// - No back-pressure. Each din_valid=1 cycle consumes one column; din_valid=0 stalls nothing, and the window holds.
// - Stage 1 (column sum):
//   - csum = row0+row1+row2, registered, width PW+2.
//   - Shift into a 3-deep column-sum window only on a valid beat.
// - Column counter:
//   - Increments on each valid beat and wraps IMAGE_WIDTH-1 -> 0.
//   - A window is complete when the current beat is column index >= 2 of its line.
//   - The first two beats of each line produce no output: IMAGE_WIDTH-2 outputs per line, no wrap across lines.
// - Stage 2 (window sum): wsum = sum of the 3 column sums, PW+4 bits, no truncation.
// - Stage 3 (capture): sum_out/sum_valid register wsum and its valid tag; sum_out holds its last value when not valid.
// - Stage 4 (divide):
//   - data_out = floor(sum_out/9), exact for 0..2295; a reciprocal multiply is allowed if exact over the range.
//   - dout_valid = registered sum_valid; data_out holds when not valid.
// - Latency, counted from the rising edge that samples a window-completing beat:
//   - sum_valid rises 3 clocks later.
//   - dout_valid rises 4 clocks later.
//   - One output per qualifying beat, in order.
// - Valid gaps: the valid tag travels with the data; output spacing mirrors input spacing.
// - Reset mid-line: pipeline flushed, counter to 0; the next valid beat is treated as column 0 of a new line.
// - Simultaneous din_valid and reset: reset wins.
// CONFIGURATION
// - AVG_ROUND_EN defined:
//   - data_out = floor((sum_out+4)/9), i.e. round-half-up.
//   - Max 2299/9 = 255, so no overflow.
// - AVG_ROUND_EN undefined: data_out = floor(sum_out/9), i.e. truncate (default).
// - Latency and sum_out are identical in both builds.
// TESTING
// - Ramp line, all 3 rows = j for j=1..128, one beat/clk:
//   - 126 outputs.
//   - First: sum_out=18, data_out=2.
//   - Last: sum_out=1143, data_out=127 (output k: 9k+18 -> k+2).
// - Six back-to-back ramp lines: exactly 756 dout_valid pulses, and the 2-beat gap per line is honoured at every wrap.
// - All pixels 255: sum_out=2295, data_out=255 (both builds).
// - Window sum 13 -> data_out 1 in both builds. Window sum 14 -> 1 (truncate) / 2 (AVG_ROUND_EN).
// - din_valid toggled 1/0 each clock: outputs identical to the dense run, and dout_valid is spaced every 2 clocks.
// - arstn pulsed mid-line:
//   - All outputs 0 immediately.
//   - The next beats restart column count; the first output appears at the 3rd beat after release.

Source files
------------

// File: rtl/avg3x3_window_filter.sv
// +-----------------------------------------------------------------------------+
// | Module      : avg3x3_window_filter                                          |
// | Description : Streaming 3x3 box (mean) filter. Column sums feed a 3-deep    |
// |               window whose sum is registered and divided by 9.              |
// |               Optional macro AVG_ROUND_EN selects round-half-up division.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module avg3x3_window_filter #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_NUM    = 3,
  parameter int KX_WIDTH    = 3,
  parameter int IMAGE_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic [PIXEL_WIDTH*LINE_NUM-1:0] data_in,
  input  logic                            din_valid,
  output logic [PIXEL_WIDTH+3:0]          sum_out,
  output logic                            sum_valid,
  output logic [PIXEL_WIDTH-1:0]          data_out,
  output logic                            dout_valid
);

  localparam int c_csw = PIXEL_WIDTH + 2;
  localparam int c_ssw = PIXEL_WIDTH + 4;
  localparam int c_nw  = PIXEL_WIDTH + 5;
  localparam int c_cw  = $clog2(IMAGE_WIDTH);
  localparam logic [c_cw-1:0] c_col_last  = c_cw'(IMAGE_WIDTH - 1);
  localparam logic [c_cw-1:0] c_col_first = c_cw'(KX_WIDTH - 1);
`ifdef AVG_ROUND_EN
  localparam logic [c_nw-1:0] c_bias = c_nw'(4);
`else
  localparam logic [c_nw-1:0] c_bias = '0;
`endif

  logic [c_cw-1:0]        r_col;
  logic [c_csw-1:0]       r_csum;
  logic                   r_csum_vld;
  logic                   r_csum_cmp;
  logic [c_csw-1:0]       r_win [KX_WIDTH];
  logic                   r_win_vld;
  logic [c_ssw-1:0]       r_wsum;
  logic                   r_wsum_vld;

  logic [c_csw-1:0]       w_csum;
  logic [c_ssw-1:0]       w_wsum;
  logic                   w_complete;
  logic [c_nw-1:0]        w_num;
  logic [PIXEL_WIDTH-1:0] w_quot;

  always_comb begin
    w_csum = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      w_csum = w_csum + c_csw'(data_in[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end
  end

  always_comb begin
    w_wsum = '0;
    for (int i = 0; i < KX_WIDTH; i++) begin
      w_wsum = w_wsum + c_ssw'(r_win[i]);
    end
  end

  // A window is complete once the current beat is at least the third of its line.
  assign w_complete = din_valid && (r_col >= c_col_first);
  assign w_num      = c_nw'(sum_out) + c_bias;
  assign w_quot     = PIXEL_WIDTH'(w_num / c_nw'(9));

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      r_col      <= '0;
      r_csum     <= '0;
      r_csum_vld <= 1'b0;
      r_csum_cmp <= 1'b0;
      for (int i = 0; i < KX_WIDTH; i++) begin
        r_win[i] <= '0;
      end
      r_win_vld  <= 1'b0;
      r_wsum     <= '0;
      r_wsum_vld <= 1'b0;
      sum_out    <= '0;
      sum_valid  <= 1'b0;
      data_out   <= '0;
      dout_valid <= 1'b0;
    end else begin
      r_csum_vld <= din_valid;
      r_csum_cmp <= w_complete;
      if (din_valid) begin
        r_csum <= w_csum;
        r_col  <= (r_col == c_col_last) ? '0 : r_col + c_cw'(1);
      end

      // The window only moves on valid beats so gaps leave it untouched.
      r_win_vld <= r_csum_vld && r_csum_cmp;
      if (r_csum_vld) begin
        for (int i = KX_WIDTH - 1; i > 0; i--) begin
          r_win[i] <= r_win[i-1];
        end
        r_win[0] <= r_csum;
      end

      r_wsum_vld <= r_win_vld;
      if (r_win_vld) begin
        r_wsum <= w_wsum;
      end

      sum_valid <= r_wsum_vld;
      if (r_wsum_vld) begin
        sum_out <= r_wsum;
      end

      dout_valid <= sum_valid;
      if (sum_valid) begin
        data_out <= w_quot;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avg3x3_window_filter.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_avg3x3_window_filter                                       |
// | Description : Bench for avg3x3_window_filter; reference model predicts each |
// |               window sum, averaged pixel and arrival cycle.                 |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_avg3x3_window_filter;

  logic        clk;
  logic        arstn;
  logic [23:0] data_in;
  logic        din_valid;
  logic [11:0] sum_out;
  logic        sum_valid;
  logic [7:0]  data_out;
  logic        dout_valid;

  avg3x3_window_filter #(
    .PIXEL_WIDTH(8), .LINE_NUM(3), .KX_WIDTH(3), .IMAGE_WIDTH(128)
  ) dut (
    .clk(clk), .arstn(arstn), .data_in(data_in), .din_valid(din_valid),
    .sum_out(sum_out), .sum_valid(sum_valid),
    .data_out(data_out), .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int div9(input int s);
`ifdef AVG_ROUND_EN
    return (s + 4) / 9;
`else
    return s / 9;
`endif
  endfunction

  // Reference model: per-line column history, outputs queued with due cycle.
  int cyc = 0;
  int m_col = 0;
  int m_h0 = 0, m_h1 = 0, m_h2 = 0;
  int exp_sum[$], exp_scyc[$], exp_dat[$], exp_dcyc[$];

  always @(posedge clk) begin
    cyc++;
    if (arstn) begin
      m_col = 0;
      m_h0 = 0; m_h1 = 0; m_h2 = 0;
      exp_sum.delete(); exp_scyc.delete();
      exp_dat.delete(); exp_dcyc.delete();
    end else if (din_valid) begin
      m_h2 = m_h1;
      m_h1 = m_h0;
      m_h0 = int'(data_in[7:0]) + int'(data_in[15:8]) + int'(data_in[23:16]);
      if (m_col >= 2) begin
        exp_sum.push_back(m_h0 + m_h1 + m_h2);
        exp_scyc.push_back(cyc + 3);
        exp_dat.push_back(div9(m_h0 + m_h1 + m_h2));
        exp_dcyc.push_back(cyc + 4);
      end
      m_col = (m_col == 127) ? 0 : m_col + 1;
    end
  end

  int n_sum = 0, n_dout = 0;
  int first_sum = 0, last_sum = 0, first_dat = 0, last_dat = 0;
  int last_dcyc = -1;
  bit chk_gap = 1'b0;

  always @(negedge clk) begin
    if (!arstn) begin
      if (sum_valid) begin
        if (exp_sum.size() == 0) check("sum_extra", 1, 0);
        else begin
          check("sum_out", int'(sum_out), exp_sum.pop_front());
          check("sum_lat", cyc, exp_scyc.pop_front());
        end
        if (n_sum == 0) first_sum = int'(sum_out);
        last_sum = int'(sum_out);
        n_sum++;
      end
      if (dout_valid) begin
        if (exp_dat.size() == 0) check("dout_extra", 1, 0);
        else begin
          check("data_out", int'(data_out), exp_dat.pop_front());
          check("dout_lat", cyc, exp_dcyc.pop_front());
        end
        if (chk_gap && last_dcyc >= 0) check("dout_gap", cyc - last_dcyc, 2);
        last_dcyc = cyc;
        if (n_dout == 0) first_dat = int'(data_out);
        last_dat = int'(data_out);
        n_dout++;
      end
    end
  end

  task automatic beat(input logic [7:0] r0, input logic [7:0] r1,
                      input logic [7:0] r2, input logic v);
    @(posedge clk);
    #1;
    data_in   = {r2, r1, r0};
    din_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    arstn = 1'b1;
    #1;
    check("rst_sum_out", int'(sum_out), 0);
    check("rst_sum_valid", int'(sum_valid), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arstn     = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic clear_stats();
    n_sum = 0; n_dout = 0; last_dcyc = -1;
  endtask

  initial begin
    int snap;
    int exp14;
    arstn     = 1'b1;
    data_in   = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_sum_out", int'(sum_out), 0);
    check("init_sum_valid", int'(sum_valid), 0);
    check("init_data_out", int'(data_out), 0);
    check("init_dout_valid", int'(dout_valid), 0);
    arstn = 1'b0;

    // Six dense ramp lines.
    clear_stats();
    for (int l = 0; l < 6; l++)
      for (int j = 1; j <= 128; j++) beat(8'(j), 8'(j), 8'(j), 1'b1);
    idle(8);
    check("ramp_n_dout", n_dout, 756);
    check("ramp_n_sum", n_sum, 756);
    check("ramp_first_sum", first_sum, 18);
    check("ramp_first_dat", first_dat, 2);
    check("ramp_last_sum", last_sum, 1143);
    check("ramp_last_dat", last_dat, 127);

    // One ramp line with din_valid toggling each clock.
    clear_stats();
    chk_gap = 1'b1;
    for (int j = 1; j <= 128; j++) begin
      beat(8'(j), 8'(j), 8'(j), 1'b1);
      beat(8'd0, 8'd0, 8'd0, 1'b0);
    end
    idle(8);
    chk_gap = 1'b0;
    check("tog_n_dout", n_dout, 126);
    check("tog_first_dat", first_dat, 2);
    check("tog_last_sum", last_sum, 1143);

    // Saturated window.
    pulse_reset();
    repeat (3) beat(8'd255, 8'd255, 8'd255, 1'b1);
    idle(8);
    check("max_sum", last_sum, 2295);
    check("max_dat", last_dat, 255);

    // Rounding boundaries.
    pulse_reset();
    beat(8'd5, 8'd0, 8'd0, 1'b1);
    beat(8'd4, 8'd0, 8'd0, 1'b1);
    beat(8'd4, 8'd0, 8'd0, 1'b1);
    idle(8);
    check("s13_sum", last_sum, 13);
    check("s13_dat", last_dat, 1);
    pulse_reset();
    beat(8'd5, 8'd0, 8'd0, 1'b1);
    beat(8'd5, 8'd0, 8'd0, 1'b1);
    beat(8'd4, 8'd0, 8'd0, 1'b1);
    idle(8);
`ifdef AVG_ROUND_EN
    exp14 = 2;
`else
    exp14 = 1;
`endif
    check("s14_sum", last_sum, 14);
    check("s14_dat", last_dat, exp14);

    // Reset in the middle of a line restarts the column count.
    for (int j = 1; j <= 50; j++) beat(8'(j), 8'(j), 8'(j), 1'b1);
    pulse_reset();
    snap = n_sum;
    beat(8'd10, 8'd10, 8'd10, 1'b1);
    beat(8'd10, 8'd10, 8'd10, 1'b1);
    idle(6);
    check("mid_rst_no_out", n_sum - snap, 0);
    beat(8'd10, 8'd10, 8'd10, 1'b1);
    idle(6);
    check("mid_rst_one_out", n_sum - snap, 1);
    check("mid_rst_sum", last_sum, 90);
    check("mid_rst_dat", last_dat, 10);

    // Random pixels with random valid gaps and one reset.
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) pulse_reset();
      beat(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 9) < 7);
    end
    idle(8);
    check("left_sum", exp_sum.size(), 0);
    check("left_dat", exp_dat.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
